// File: rtl/wb_regfile_if.sv
// Bus bundle between the execute stage, the write-back/register-file block and decode.
// The master modport is the execute/decode side and the slave modport is wb_regfile.
interface wb_regfile_if;
    logic [7:0] FU;
    logic [7:0] MEM;
    logic [2:0] DA;
    logic [1:0] MD;
    logic       RW;
    logic       LT;
    logic       Z;
    logic       C;
    logic       N;
    logic       V;
    logic [2:0] AA;
    logic [2:0] BA;
    logic [7:0] A_data;
    logic [7:0] B_data;
    logic [7:0] WD;
    logic [4:0] STAT;
    logic [7:0] wr_cnt;
    logic       md_err;

    modport master (
        output FU, MEM, DA, MD, RW, LT, Z, C, N, V, AA, BA,
        input  A_data, B_data, WD, STAT, wr_cnt, md_err
    );

    modport slave (
        input  FU, MEM, DA, MD, RW, LT, Z, C, N, V, AA, BA,
        output A_data, B_data, WD, STAT, wr_cnt, md_err
    );
endinterface

// File: rtl/wb_regfile.sv
// Write-back select, 8x8 register file, ALU status register and write counter.
// Optional macro WB_FWD_BYPASS_EN forwards WD to a read port whose address matches DA.
module wb_regfile #(
    parameter bit R0_ZERO = 1'b1,
    parameter int NREG    = 8
) (
    input logic         clk,
    input logic         rst_n,
    wb_regfile_if.slave bus
);

    logic [7:0] regs [NREG];
    logic       we;
    logic       r0_hit;
    logic       md_illegal;

    always_comb begin
        bus.WD = 8'h00;
        case (bus.MD)
            2'b00:   bus.WD = bus.FU;
            2'b01:   bus.WD = bus.MEM;
            2'b10:   bus.WD = {7'b0, bus.LT};
            default: bus.WD = 8'h00;
        endcase
    end

    assign r0_hit     = R0_ZERO && (bus.DA == 3'd0);
    assign md_illegal = bus.RW && (bus.MD == 2'b11);
    assign we         = bus.RW && (bus.MD != 2'b11) && !r0_hit;

    // NOTE: the register array is reset explicitly because a cleared file is part of the
    // architectural reset state; this forces flops rather than a RAM macro, which is fine at 8x8.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= 8'h00;
        end else if (we) begin
            regs[bus.DA] <= bus.WD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.STAT   <= 5'b0;
            bus.wr_cnt <= 8'h00;
            bus.md_err <= 1'b0;
        end else begin
            // Flags track every ALU-sourced write request, even one discarded by R0.
            if (bus.RW && (bus.MD == 2'b00))
                bus.STAT <= {bus.LT, bus.V, bus.N, bus.C, bus.Z};
            if (we)
                bus.wr_cnt <= bus.wr_cnt + 8'd1;
            if (md_illegal)
                bus.md_err <= 1'b1;
        end
    end

    always_comb begin
        bus.A_data = regs[bus.AA];
        if (R0_ZERO && (bus.AA == 3'd0))
            bus.A_data = 8'h00;
`ifdef WB_FWD_BYPASS_EN
        else if (we && (bus.AA == bus.DA))
            bus.A_data = bus.WD;
`endif
    end

    always_comb begin
        bus.B_data = regs[bus.BA];
        if (R0_ZERO && (bus.BA == 3'd0))
            bus.B_data = 8'h00;
`ifdef WB_FWD_BYPASS_EN
        else if (we && (bus.BA == bus.DA))
            bus.B_data = bus.WD;
`endif
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset, WD select, commit, STAT, md_err, R0, wrap, bypass.
// Build with or without WB_FWD_BYPASS_EN; expectations follow the macro.
module tb_wb_regfile;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    wb_regfile_if bus ();

    wb_regfile #(.R0_ZERO(1'b1), .NREG(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        bus.FU = 8'h5A; bus.MEM = 8'h00; bus.DA = 3'd1; bus.MD = 2'b00; bus.RW = 1'b1;
        bus.LT = 1'b0; bus.Z = 1'b0; bus.C = 1'b0; bus.N = 1'b0; bus.V = 1'b0;
        bus.AA = 3'd0; bus.BA = 3'd0;
        tick(); tick();
        for (int i = 0; i < 8; i++) begin
            bus.AA = 3'(i);
            #1;
            checks++;
            if (bus.A_data !== 8'h00) begin
                errors++;
                $display("FAIL reset_reg%0d A_data=%h expected=00", i, bus.A_data);
            end
        end
        checks++;
        if (bus.wr_cnt !== 8'h00) begin errors++; $display("FAIL reset_wr_cnt got=%h expected=00", bus.wr_cnt); end
        checks++;
        if (bus.STAT !== 5'b0) begin errors++; $display("FAIL reset_stat got=%b expected=00000", bus.STAT); end
        checks++;
        if (bus.md_err !== 1'b0) begin errors++; $display("FAIL reset_md_err got=%b expected=0", bus.md_err); end
        rst_n = 1'b1;
        tick();
        bus.RW = 1'b0;
        bus.AA = 3'd1;
        #1;
        checks++;
        if (bus.A_data !== 8'h5A) begin errors++; $display("FAIL release_write A_data=%h expected=5a", bus.A_data); end
        checks++;
        if (bus.wr_cnt !== 8'h01) begin errors++; $display("FAIL release_wr_cnt got=%h expected=01", bus.wr_cnt); end
    endtask

    task automatic test_alu_write();
        bus.RW = 1'b1; bus.MD = 2'b00; bus.DA = 3'd3; bus.FU = 8'h7F;
        bus.Z = 1'b0; bus.C = 1'b1; bus.N = 1'b0; bus.V = 1'b1; bus.LT = 1'b1;
        tick();
        bus.RW = 1'b0; bus.AA = 3'd3;
        #1;
        checks++;
        if (bus.A_data !== 8'h7F) begin errors++; $display("FAIL alu_read A_data=%h expected=7f", bus.A_data); end
        checks++;
        if (bus.STAT !== 5'b11010) begin errors++; $display("FAIL alu_stat got=%b expected=11010", bus.STAT); end
        checks++;
        if (bus.wr_cnt !== 8'h02) begin errors++; $display("FAIL alu_wr_cnt got=%h expected=02", bus.wr_cnt); end
    endtask

    task automatic test_mem_lt();
        bus.Z = 1'b1; bus.C = 1'b0; bus.N = 1'b1; bus.V = 1'b0; bus.LT = 1'b0;
        bus.RW = 1'b1; bus.MD = 2'b01; bus.DA = 3'd5; bus.MEM = 8'hC3; bus.FU = 8'h11;
        #1;
        checks++;
        if (bus.WD !== 8'hC3) begin errors++; $display("FAIL wd_mem got=%h expected=c3", bus.WD); end
        tick();
        checks++;
        if (bus.STAT !== 5'b11010) begin errors++; $display("FAIL mem_stat_hold got=%b expected=11010", bus.STAT); end
        bus.MD = 2'b10; bus.DA = 3'd6; bus.LT = 1'b1;
        #1;
        checks++;
        if (bus.WD !== 8'h01) begin errors++; $display("FAIL wd_lt got=%h expected=01", bus.WD); end
        tick();
        bus.RW = 1'b0; bus.AA = 3'd5; bus.BA = 3'd6;
        #1;
        checks++;
        if (bus.A_data !== 8'hC3) begin errors++; $display("FAIL mem_read A_data=%h expected=c3", bus.A_data); end
        checks++;
        if (bus.B_data !== 8'h01) begin errors++; $display("FAIL lt_read B_data=%h expected=01", bus.B_data); end
        checks++;
        if (bus.STAT !== 5'b11010) begin errors++; $display("FAIL lt_stat_hold got=%b expected=11010", bus.STAT); end
        checks++;
        if (bus.wr_cnt !== 8'h04) begin errors++; $display("FAIL mem_lt_wr_cnt got=%h expected=04", bus.wr_cnt); end
    endtask

    task automatic test_illegal_md();
        bus.Z = 1'b0; bus.C = 1'b0; bus.N = 1'b0; bus.V = 1'b0; bus.LT = 1'b0;
        bus.RW = 1'b1; bus.MD = 2'b00; bus.DA = 3'd2; bus.FU = 8'h22;
        tick();
        bus.MD = 2'b11; bus.FU = 8'h33;
        #1;
        checks++;
        if (bus.WD !== 8'h00) begin errors++; $display("FAIL wd_md11 got=%h expected=00", bus.WD); end
        checks++;
        if (bus.md_err !== 1'b0) begin errors++; $display("FAIL md_err_pre got=%b expected=0", bus.md_err); end
        tick();
        bus.RW = 1'b0; bus.MD = 2'b00; bus.AA = 3'd2;
        #1;
        checks++;
        if (bus.A_data !== 8'h22) begin errors++; $display("FAIL illegal_no_write A_data=%h expected=22", bus.A_data); end
        checks++;
        if (bus.md_err !== 1'b1) begin errors++; $display("FAIL md_err_set got=%b expected=1", bus.md_err); end
        checks++;
        if (bus.wr_cnt !== 8'h05) begin errors++; $display("FAIL illegal_wr_cnt got=%h expected=05", bus.wr_cnt); end
        bus.RW = 1'b1; bus.DA = 3'd7;
        for (int i = 0; i < 4; i++) begin
            bus.FU = 8'h70 + 8'(i);
            tick();
        end
        bus.RW = 1'b0; bus.AA = 3'd7;
        #1;
        checks++;
        if (bus.md_err !== 1'b1) begin errors++; $display("FAIL md_err_sticky got=%b expected=1", bus.md_err); end
        checks++;
        if (bus.wr_cnt !== 8'h09) begin errors++; $display("FAIL legal_after_err_wr_cnt got=%h expected=09", bus.wr_cnt); end
        checks++;
        if (bus.A_data !== 8'h73) begin errors++; $display("FAIL reg7_last A_data=%h expected=73", bus.A_data); end
    endtask

    task automatic test_r0_and_same_addr();
        bus.RW = 1'b1; bus.MD = 2'b00; bus.DA = 3'd0; bus.FU = 8'hFF;
        tick();
        bus.RW = 1'b0; bus.AA = 3'd0; bus.BA = 3'd0;
        #1;
        checks++;
        if (bus.A_data !== 8'h00) begin errors++; $display("FAIL r0_read_a A_data=%h expected=00", bus.A_data); end
        checks++;
        if (bus.B_data !== 8'h00) begin errors++; $display("FAIL r0_read_b B_data=%h expected=00", bus.B_data); end
        checks++;
        if (bus.wr_cnt !== 8'h09) begin errors++; $display("FAIL r0_wr_cnt got=%h expected=09", bus.wr_cnt); end
        bus.AA = 3'd7; bus.BA = 3'd7;
        #1;
        checks++;
        if (bus.A_data !== 8'h73 || bus.B_data !== 8'h73) begin
            errors++;
            $display("FAIL same_addr A_data=%h B_data=%h expected=73", bus.A_data, bus.B_data);
        end
    endtask

    task automatic test_wrap();
        // wr_cnt is 0x09 here: 246 more writes reach 0xFF, one more wraps to 0x00.
        bus.RW = 1'b1; bus.MD = 2'b00; bus.DA = 3'd1;
        for (int i = 0; i < 246; i++) begin
            bus.FU = 8'(i);
            tick();
        end
        bus.RW = 1'b0;
        #1;
        checks++;
        if (bus.wr_cnt !== 8'hFF) begin errors++; $display("FAIL wrap_ff got=%h expected=ff", bus.wr_cnt); end
        bus.RW = 1'b1; bus.FU = 8'hAB;
        tick();
        bus.RW = 1'b0; bus.AA = 3'd1;
        #1;
        checks++;
        if (bus.wr_cnt !== 8'h00) begin errors++; $display("FAIL wrap_00 got=%h expected=00", bus.wr_cnt); end
        checks++;
        if (bus.A_data !== 8'hAB) begin errors++; $display("FAIL wrap_data A_data=%h expected=ab", bus.A_data); end
    endtask

    task automatic test_bypass();
        logic [7:0] exp_pre;
`ifdef WB_FWD_BYPASS_EN
        exp_pre = 8'h99;
`else
        exp_pre = 8'h44;
`endif
        bus.RW = 1'b1; bus.MD = 2'b00; bus.DA = 3'd4; bus.FU = 8'h44;
        tick();
        bus.FU = 8'h99; bus.AA = 3'd4; bus.BA = 3'd4;
        #1;
        checks++;
        if (bus.A_data !== exp_pre) begin errors++; $display("FAIL bypass_pre_a A_data=%h expected=%h", bus.A_data, exp_pre); end
        checks++;
        if (bus.B_data !== exp_pre) begin errors++; $display("FAIL bypass_pre_b B_data=%h expected=%h", bus.B_data, exp_pre); end
        bus.AA = 3'd0;
        #1;
        checks++;
        if (bus.A_data !== 8'h00) begin errors++; $display("FAIL bypass_r0 A_data=%h expected=00", bus.A_data); end
        tick();
        bus.RW = 1'b0; bus.AA = 3'd4;
        #1;
        checks++;
        if (bus.A_data !== 8'h99) begin errors++; $display("FAIL bypass_post A_data=%h expected=99", bus.A_data); end
    endtask

    task automatic test_async_reset();
        bus.RW = 1'b1; bus.MD = 2'b00; bus.DA = 3'd1; bus.FU = 8'hEE;
        @(negedge clk);
        rst_n = 1'b0;
        bus.AA = 3'd4;
        #1;
        checks++;
        if (bus.A_data !== 8'h00) begin errors++; $display("FAIL async_reg A_data=%h expected=00", bus.A_data); end
        checks++;
        if (bus.wr_cnt !== 8'h00 || bus.md_err !== 1'b0) begin
            errors++;
            $display("FAIL async_cnt wr_cnt=%h md_err=%b expected=00/0", bus.wr_cnt, bus.md_err);
        end
        tick();
        rst_n = 1'b1; bus.RW = 1'b0; bus.AA = 3'd1;
        #1;
        checks++;
        if (bus.A_data !== 8'h00) begin errors++; $display("FAIL async_abort A_data=%h expected=00", bus.A_data); end
        checks++;
        if (bus.wr_cnt !== 8'h00) begin errors++; $display("FAIL async_abort_cnt got=%h expected=00", bus.wr_cnt); end
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_mem_lt();
        test_illegal_md();
        test_r0_and_same_addr();
        test_wrap();
        test_bypass();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back stage and register file of the 8-bit pipelined datapath.
- Sits directly downstream of the execute stage and consumes its registered outputs: function-unit result, memory read data, destination address, MD select, RW, flags and LT.
- Selects the write-back data, commits it to an 8x8 register file on the rising clock edge, and holds a status register of the last ALU flags.
- Supplies two read ports (A, B) to the decode stage.

Parameters:
- R0_ZERO, 1, when 1 register 0 always reads 0x00 and writes to it are discarded; when 0, R0 is an ordinary register.
- NREG, 8, number of registers (address width fixed at 3 bits; NREG must be 8).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- FU  input  8  function-unit result from execute.
- MEM  input  8  memory read data from execute.
- DA  input  3  destination register address.
- MD  input  2  write-back source select.
- RW  input  1  register write request.
- LT  input  1  less-than bit from execute.
- Z  input  1  execute flag, zero.
- C  input  1  execute flag, carry.
- N  input  1  execute flag, negative.
- V  input  1  execute flag, overflow.
- AA  input  3  read port A address.
- BA  input  3  read port B address.
- A_data  output  8  read port A data.
- B_data  output  8  read port B data.
- WD  output  8  selected write-back data (combinational).
- STAT  output  5  status register {LT,V,N,C,Z}.
- wr_cnt  output  8  count of committed register writes.
- md_err  output  1  sticky illegal-MD flag.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - all registers = 0x00, STAT = 0, wr_cnt = 0, md_err = 0.
  - A_data/B_data therefore read 0x00.
  - Reset asserted mid-cycle aborts any pending write; nothing is committed on the edge while rst_n=0.
- WD select (combinational):
  - MD=00 -> FU.
  - MD=01 -> MEM.
  - MD=10 -> {7'b0, LT}.
  - MD=11 -> 0x00.
- Write enable: we = RW & (MD != 11) & !(R0_ZERO & DA==0).
- Commit, rising edge, we=1: reg[DA] <= WD; wr_cnt <= wr_cnt+1, wrapping 0xFF -> 0x00.
- Illegal MD: RW=1 with MD=11 sets md_err=1 at the edge. No write occurs. md_err stays set until reset.
- R0 write with R0_ZERO=1: discarded and not counted. Not an error.
- STAT update, rising edge, RW=1 and MD=00: STAT <= {LT,V,N,C,Z}. Otherwise STAT holds.
- Read ports: combinational, asynchronous.
  - A_data = reg[AA], or 0x00 when R0_ZERO and AA==0.
  - B_data = reg[BA], same rule.
- Same-address reads on both ports are legal and return identical data.
- Latency: write visible on the read ports the cycle after the commit edge (bypass macro off).
- No back-pressure. One write per cycle max; execute outputs are held stable across the rising edge.

Optional Feature:
- Macro WB_FWD_BYPASS_EN.
- Defined: when we=1 and AA==DA (or BA==DA), the matching port returns WD combinationally in the same cycle, before the commit edge. R0_ZERO still forces 0x00 for address 0.
- Undefined: read ports return stored contents only; the new value appears after the edge.

Test Plan:
- Reset with FU=0x5A, RW=1 held -> all regs 0x00, wr_cnt=0, STAT=0; release rst_n, one edge -> reg[DA] written once, wr_cnt=1.
- RW=1, MD=00, DA=3, FU=0x7F, Z=0 C=1 N=0 V=1 LT=1 -> next cycle AA=3 reads 0x7F, STAT=5'b11010, wr_cnt increments.
- RW=1, MD=01, DA=5, MEM=0xC3, then MD=10, DA=6, LT=1 -> reg5=0xC3, reg6=0x01, STAT unchanged both cycles.
- RW=1, MD=11, DA=2 -> reg2 unchanged, md_err=1 and stays 1 after 4 further legal writes; wr_cnt unchanged on the illegal cycle.
- RW=1, DA=0, FU=0xFF with R0_ZERO=1 -> A_data(AA=0)=0x00, wr_cnt unchanged; 256 legal writes -> wr_cnt wraps to 0x00.
- WB_FWD_BYPASS_EN defined: RW=1, MD=00, DA=4, FU=0x99, AA=4 -> A_data=0x99 before the edge; macro undefined -> old reg4 value before the edge, 0x99 after.
